// File: rtl/clock_pkg.sv
// Shared widths, digit limits and state encoding for the time-of-day counter.
package clock_pkg;

  localparam int unsigned HOUR_TENS_W    = 2;
  localparam int unsigned TENS_W         = 3;
  localparam int unsigned ONES_W         = 4;

  localparam int unsigned ONES_MAX       = 9;
  localparam int unsigned TENS_MAX       = 5;
  localparam int unsigned HOUR_TENS_MAX  = 2;
  localparam int unsigned HOUR_WRAP_TENS = 2;
  localparam int unsigned HOUR_WRAP_ONES = 3;

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } state_t;

  // Elaboration-time split of a binary reset constant into BCD digits.
  function automatic int unsigned tens_of(input int unsigned v);
    return v / 10;
  endfunction

  function automatic int unsigned ones_of(input int unsigned v);
    return v % 10;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: counts 0..MAX on Inc, clears on Clr, flags Carry on MAX->0.
module bcd_digit_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MAX         = 9,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Inc,
  input  logic             Clr,
  output logic [WIDTH-1:0] Value,
  output logic             Carry
);

  logic at_max_c;

  assign at_max_c = (Value == WIDTH'(MAX));
  assign Carry    = Inc && at_max_c;

  // Clr has priority so a joint wrap can override a pending increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Value <= WIDTH'(RESET_VALUE);
    end else if (Clr) begin
      Value <= '0;
    end else if (Inc) begin
      Value <= at_max_c ? '0 : Value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time-of-day counter with a set mode for adjusting hours/minutes.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int unsigned RESET_HOUR   = 0,
  parameter int unsigned RESET_MINUTE = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Tick,
  input  logic                   SetMode,
  input  logic                   IncHour,
  input  logic                   IncMin,
  output logic [HOUR_TENS_W-1:0] HourTens,
  output logic [ONES_W-1:0]      HourOnes,
  output logic [TENS_W-1:0]      MinTens,
  output logic [ONES_W-1:0]      MinOnes,
  output logic [TENS_W-1:0]      SecTens,
  output logic [ONES_W-1:0]      SecOnes,
  output logic                   InSet,
  output logic                   DayWrap
);

  state_t state_q, state_d;
  logic   run_c, set_c;

  logic sec_ones_inc_c, sec_clr_c;
  logic sec_ones_carry_c, sec_tens_carry_c;
  logic min_ones_inc_c, min_ones_carry_c, min_tens_carry_c;
  logic hour_from_min_c, hour_inc_c, hour_wrap_c, hour_clr_c;
  logic hour_ones_carry_c, hour_tens_carry_c;

  // State and registered status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      InSet   <= 1'b0;
      DayWrap <= 1'b0;
    end else begin
      state_q <= state_d;
      InSet   <= (state_d == SET);
      DayWrap <= hour_wrap_c && hour_from_min_c;
    end
  end

  // Counting/adjust enables only apply on cycles that stay in the same state.
  always_comb begin
    state_d = state_q;
    run_c   = 1'b0;
    set_c   = 1'b0;
    case (state_q)
      RUN: begin
        if (SetMode) state_d = SET;
        else         run_c   = 1'b1;
      end
      SET: begin
        if (!SetMode) state_d = RUN;
        else          set_c   = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  assign sec_ones_inc_c  = run_c && Tick;
  assign sec_clr_c       = SetMode;
  assign min_ones_inc_c  = sec_tens_carry_c || (set_c && IncMin);
  assign hour_from_min_c = min_tens_carry_c && run_c;
  assign hour_inc_c      = hour_from_min_c || (set_c && IncHour);
  assign hour_wrap_c     = hour_inc_c
                           && (HourTens == HOUR_TENS_W'(HOUR_WRAP_TENS))
                           && (HourOnes == ONES_W'(HOUR_WRAP_ONES));
  // A tens carry past the top hour can only mean wrap, so fold it into the clear.
  assign hour_clr_c      = hour_wrap_c || hour_tens_carry_c;

  bcd_digit_counter #(.WIDTH(ONES_W), .MAX(ONES_MAX), .RESET_VALUE(0)) u_sec_ones (
    .CLK(CLK), .RST(RST), .Inc(sec_ones_inc_c), .Clr(sec_clr_c),
    .Value(SecOnes), .Carry(sec_ones_carry_c)
  );

  bcd_digit_counter #(.WIDTH(TENS_W), .MAX(TENS_MAX), .RESET_VALUE(0)) u_sec_tens (
    .CLK(CLK), .RST(RST), .Inc(sec_ones_carry_c), .Clr(sec_clr_c),
    .Value(SecTens), .Carry(sec_tens_carry_c)
  );

  bcd_digit_counter #(.WIDTH(ONES_W), .MAX(ONES_MAX),
                      .RESET_VALUE(ones_of(RESET_MINUTE))) u_min_ones (
    .CLK(CLK), .RST(RST), .Inc(min_ones_inc_c), .Clr(1'b0),
    .Value(MinOnes), .Carry(min_ones_carry_c)
  );

  bcd_digit_counter #(.WIDTH(TENS_W), .MAX(TENS_MAX),
                      .RESET_VALUE(tens_of(RESET_MINUTE))) u_min_tens (
    .CLK(CLK), .RST(RST), .Inc(min_ones_carry_c), .Clr(1'b0),
    .Value(MinTens), .Carry(min_tens_carry_c)
  );

  bcd_digit_counter #(.WIDTH(ONES_W), .MAX(ONES_MAX),
                      .RESET_VALUE(ones_of(RESET_HOUR))) u_hour_ones (
    .CLK(CLK), .RST(RST), .Inc(hour_inc_c), .Clr(hour_clr_c),
    .Value(HourOnes), .Carry(hour_ones_carry_c)
  );

  bcd_digit_counter #(.WIDTH(HOUR_TENS_W), .MAX(HOUR_TENS_MAX),
                      .RESET_VALUE(tens_of(RESET_HOUR))) u_hour_tens (
    .CLK(CLK), .RST(RST), .Inc(hour_ones_carry_c), .Clr(hour_clr_c),
    .Value(HourTens), .Carry(hour_tens_carry_c)
  );

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for time_of_day_counter: driver queues expectations, monitor checks them.
module tb_time_of_day_counter;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic Tick = 1'b0, SetMode = 1'b0, IncHour = 1'b0, IncMin = 1'b0;
  logic [1:0] HourTens;
  logic [3:0] HourOnes, MinOnes, SecOnes;
  logic [2:0] MinTens, SecTens;
  logic InSet, DayWrap;

  logic z_tick = 1'b0, z_set = 1'b0, z_ih = 1'b0, z_im = 1'b0;
  logic [1:0] HourTens2;
  logic [3:0] HourOnes2, MinOnes2, SecOnes2;
  logic [2:0] MinTens2, SecTens2;
  logic InSet2, DayWrap2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          chk_time;
    logic [19:0] digits;
    logic        in_set;
    logic        day_wrap;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  time_of_day_counter dut (
    .CLK(CLK), .RST(RST), .Tick(Tick), .SetMode(SetMode),
    .IncHour(IncHour), .IncMin(IncMin),
    .HourTens(HourTens), .HourOnes(HourOnes), .MinTens(MinTens),
    .MinOnes(MinOnes), .SecTens(SecTens), .SecOnes(SecOnes),
    .InSet(InSet), .DayWrap(DayWrap)
  );

  time_of_day_counter #(.RESET_HOUR(13), .RESET_MINUTE(45)) dut2 (
    .CLK(CLK), .RST(RST), .Tick(z_tick), .SetMode(z_set),
    .IncHour(z_ih), .IncMin(z_im),
    .HourTens(HourTens2), .HourOnes(HourOnes2), .MinTens(MinTens2),
    .MinOnes(MinOnes2), .SecTens(SecTens2), .SecOnes(SecOnes2),
    .InSet(InSet2), .DayWrap(DayWrap2)
  );

  function automatic logic [19:0] bcd(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic string fmt(input logic [19:0] v);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d", v[19:18], v[17:14], v[13:11], v[10:7], v[6:4], v[3:0]);
  endfunction

  task automatic cmp_time(input string name, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s time: got %s expected %s at %0t", name, fmt(got), fmt(exp), $time);
    end
  endtask

  task automatic cmp_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and queue the state expected after the next edge.
  task automatic drive(input logic tk, input logic sm, input logic ih, input logic im,
                       input bit chk, input int h, input int m, input int s,
                       input logic ins, input logic dw, input string name);
    exp_t e;
    @(negedge CLK);
    Tick = tk; SetMode = sm; IncHour = ih; IncMin = im;
    e.chk_time = chk;
    e.digits   = bcd(h, m, s);
    e.in_set   = ins;
    e.day_wrap = dw;
    e.name     = name;
    exp_q.push_back(e);
  endtask

  // Monitor: every registered update is compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_time)
          cmp_time(e.name, {HourTens, HourOnes, MinTens, MinOnes, SecTens, SecOnes}, e.digits);
        cmp_bit({e.name, " InSet"}, InSet, e.in_set);
        cmp_bit({e.name, " DayWrap"}, DayWrap, e.day_wrap);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Preset time via set mode and run-mode ticks, ending in RUN at h:m:s.
  task automatic preset(input int cur_h, input int cur_m, input int h, input int m, input int s);
    int hh;
    int mm;
    hh = cur_h; mm = cur_m;
    drive(0, 1, 0, 0, 1, hh, mm, 0, 1, 0, "enter_set");
    while (hh != h) begin
      hh = (hh + 1) % 24;
      drive(0, 1, 1, 0, 1, hh, mm, 0, 1, 0, "set_inc_hour");
    end
    while (mm != m) begin
      mm = (mm + 1) % 60;
      drive(0, 1, 0, 1, 1, hh, mm, 0, 1, 0, "set_inc_min");
    end
    drive(0, 0, 0, 0, 1, hh, mm, 0, 0, 0, "leave_set");
    for (int i = 1; i <= s; i++)
      drive(1, 0, 0, 0, 1, hh, mm, i, 0, 0, "run_tick");
  endtask

  initial begin
    #2 RST = 1'b1;
    #1;
    cmp_time("reset_default", {HourTens, HourOnes, MinTens, MinOnes, SecTens, SecOnes}, bcd(0, 0, 0));
    cmp_bit("reset_default InSet", InSet, 1'b0);
    cmp_bit("reset_default DayWrap", DayWrap, 1'b0);
    cmp_time("reset_param", {HourTens2, HourOnes2, MinTens2, MinOnes2, SecTens2, SecOnes2}, bcd(13, 45, 0));
    cmp_bit("reset_param InSet", InSet2, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    // Seconds count and carry into minutes.
    for (int i = 1; i <= 58; i++) drive(1, 0, 0, 0, 1, 0, 0, i, 0, 0, "run_tick");
    drive(1, 0, 0, 0, 1, 0, 0, 59, 0, 0, "tick_00_00_59");
    drive(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, "tick_00_01_00");

    preset(0, 1, 9, 59, 59);
    drive(1, 0, 0, 0, 1, 10, 0, 0, 0, 0, "carry_09_to_10");
    preset(10, 0, 19, 59, 59);
    drive(1, 0, 0, 0, 1, 20, 0, 0, 0, 0, "carry_19_to_20");
    preset(20, 0, 23, 59, 59);
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, "day_wrap");
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "day_wrap_clear");

    // Set-mode entry clears seconds; set-mode wraps never pulse DayWrap.
    preset(0, 0, 12, 34, 27);
    drive(0, 1, 0, 0, 1, 12, 34, 0, 1, 0, "set_entry_clear_sec");
    for (int i = 1; i <= 26; i++) drive(0, 1, 0, 1, 1, 12, (34 + i) % 60, 0, 1, 0, "set_min_wrap");
    for (int i = 1; i <= 12; i++) drive(0, 1, 1, 0, 1, (12 + i) % 24, 0, 0, 1, 0, "set_hour_wrap");
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 1, 0, 0, 0, 1, 0, "set_tick_ignored");

    // Joint IncHour/IncMin at 23:59 in SET, then exit and RUN-mode Inc pulses.
    for (int i = 1; i <= 23; i++) drive(0, 1, 1, 0, 1, i, 0, 0, 1, 0, "set_inc_hour");
    for (int i = 1; i <= 59; i++) drive(0, 1, 0, 1, 1, 23, i, 0, 1, 0, "set_inc_min");
    drive(0, 1, 1, 1, 1, 0, 0, 0, 1, 0, "set_both_at_2359");
    drive(1, 0, 1, 1, 1, 0, 0, 0, 0, 0, "exit_tick_inc_ignored");
    drive(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, "run_inc_hour_ignored");
    drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, "run_inc_min_ignored");
    drive(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, "run_inc_both_ignored");
    drive(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, "resume_tick");

    // Tick on the RUN->SET edge is dropped.
    preset(0, 0, 5, 6, 7);
    drive(1, 1, 0, 0, 1, 5, 6, 0, 1, 0, "tick_on_set_entry");
    drive(0, 0, 0, 0, 1, 5, 6, 0, 0, 0, "leave_set");

    // Asynchronous reset mid-count in RUN.
    preset(5, 6, 17, 22, 41);
    @(posedge CLK);
    #3;
    Tick = 1'b0; SetMode = 1'b0; IncHour = 1'b0; IncMin = 1'b0;
    RST = 1'b1;
    #1;
    cmp_time("async_rst_run", {HourTens, HourOnes, MinTens, MinOnes, SecTens, SecOnes}, bcd(0, 0, 0));
    cmp_bit("async_rst_run DayWrap", DayWrap, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    // Asynchronous reset while in SET.
    drive(0, 1, 0, 0, 1, 0, 0, 0, 1, 0, "enter_set");
    drive(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, "set_inc_hour");
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    cmp_time("async_rst_set", {HourTens, HourOnes, MinTens, MinOnes, SecTens, SecOnes}, bcd(0, 0, 0));
    cmp_bit("async_rst_set InSet", InSet, 1'b0);
    @(negedge CLK);
    SetMode = 1'b0; IncHour = 1'b0; RST = 1'b0;
    drive(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, "post_reset_run_tick");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "idle");

    @(posedge CLK);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
